// File: rtl/pico_fetch.sv
// pico_fetch: instruction fetch and control-flow sequencer for the pico core.
// Fetches one word per PC value over req/ack, presents it downstream, then steps the PC once.
module pico_fetch #(
  parameter int unsigned pico_A  = 10,
  parameter int unsigned pico_N  = 8,
  parameter int unsigned INSTR_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [pico_A-1:0]  pc_addr_i,
  output logic               pc_halt_o,
  output logic [1:0]         pc_mode_o,
  output logic [pico_N-1:0]  pc_data_o,
  output logic               mem_req_o,
  output logic [pico_A-1:0]  mem_addr_o,
  input  logic               mem_ack_i,
  input  logic [INSTR_W-1:0] mem_data_i,
  input  logic               flag_i,
  output logic               instr_valid_o,
  input  logic               instr_ready_i,
  output logic [INSTR_W-1:0] instr_o,
  input  logic               resume_i,
  output logic               halted_o,
  output logic               illegal_o,
  output logic [15:0]        retired_o
);

  localparam int unsigned RET_W = 16;

  localparam logic [1:0] MODE_RETURN     = 2'd0;
  localparam logic [1:0] MODE_INCREMENT  = 2'd1;
  localparam logic [1:0] MODE_RELATIVE   = 2'd2;
  localparam logic [1:0] MODE_SUBROUTINE = 2'd3;

  localparam logic [2:0] CLS_NORMAL = 3'b000;
  localparam logic [2:0] CLS_BRANCH = 3'b001;
  localparam logic [2:0] CLS_CALL   = 3'b010;
  localparam logic [2:0] CLS_RETURN = 3'b011;
  localparam logic [2:0] CLS_HALT   = 3'b111;

  typedef enum logic [1:0] {
    S_FETCH    = 2'd0,
    S_DISPATCH = 2'd1,
    S_HALTED   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic [RET_W-1:0]    retired_q, retired_d;
  logic [2:0]          cls;
  logic                cond;
  logic                is_halt;

  assign cls     = instr_q[INSTR_W-1 -: 3];
  assign cond    = instr_q[INSTR_W-4];
  assign is_halt = (cls == CLS_HALT);

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Instruction register and retire counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      instr_q   <= '0;
      retired_q <= '0;
    end else begin
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:    if (mem_ack_i) state_d = S_DISPATCH;
      S_DISPATCH: begin
        if (is_halt)            state_d = S_HALTED;
        else if (instr_ready_i) state_d = S_FETCH;
      end
      S_HALTED:   if (resume_i) state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // Outputs; the PC only moves in the single cycle pc_halt_o is low
  always_comb begin
    pc_halt_o     = 1'b1;
    pc_mode_o     = MODE_INCREMENT;
    pc_data_o     = '0;
    mem_req_o     = 1'b0;
    instr_valid_o = 1'b0;
    halted_o      = 1'b0;
    illegal_o     = 1'b0;
    instr_d       = instr_q;
    retired_d     = retired_q;
    unique case (state_q)
      S_FETCH: begin
        mem_req_o = 1'b1;
        if (mem_ack_i) instr_d = mem_data_i;
      end
      S_DISPATCH: begin
        pc_data_o = instr_q[pico_N-1:0];
        if (is_halt) begin
          pc_halt_o = 1'b0;
        end else begin
          instr_valid_o = 1'b1;
          if (instr_ready_i) begin
            pc_halt_o = 1'b0;
            retired_d = retired_q + RET_W'(1);
            case (cls)
              CLS_NORMAL: pc_mode_o = MODE_INCREMENT;
              CLS_BRANCH: pc_mode_o = (!cond || flag_i) ? MODE_RELATIVE : MODE_INCREMENT;
              CLS_CALL:   pc_mode_o = MODE_SUBROUTINE;
              CLS_RETURN: pc_mode_o = MODE_RETURN;
              default:    illegal_o = 1'b1;
            endcase
          end
        end
      end
      S_HALTED: halted_o = 1'b1;
      default: ;
    endcase
    // Hold the PC and memory quiet during the reset cycle itself
    if (rst_i) begin
      pc_halt_o     = 1'b1;
      pc_mode_o     = MODE_INCREMENT;
      pc_data_o     = '0;
      mem_req_o     = 1'b0;
      instr_valid_o = 1'b0;
      halted_o      = 1'b0;
      illegal_o     = 1'b0;
    end
  end

  assign mem_addr_o = pc_addr_i;
  assign instr_o    = instr_q;
  assign retired_o  = retired_q;

endmodule

// File: tb/tb_pico_fetch.sv
// Self-checking bench for pico_fetch: behavioural PC and program memory around the DUT,
// with a scoreboard of expected fetch addresses and PC-advance commands.
module tb_pico_fetch;
  localparam int unsigned AW = 10;
  localparam int unsigned NW = 8;
  localparam int unsigned IW = 16;

  logic          clk = 1'b0;
  logic          rst_i;
  logic [AW-1:0] pc_addr_i;
  logic          pc_halt_o;
  logic [1:0]    pc_mode_o;
  logic [NW-1:0] pc_data_o;
  logic          mem_req_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_ack_i;
  logic [IW-1:0] mem_data_i;
  logic          flag_i;
  logic          instr_valid_o;
  logic          instr_ready_i;
  logic [IW-1:0] instr_o;
  logic          resume_i;
  logic          halted_o;
  logic          illegal_o;
  logic [15:0]   retired_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pico_fetch #(.pico_A(AW), .pico_N(NW), .INSTR_W(IW)) dut (
    .clk_i(clk), .rst_i(rst_i), .pc_addr_i(pc_addr_i),
    .pc_halt_o(pc_halt_o), .pc_mode_o(pc_mode_o), .pc_data_o(pc_data_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i),
    .mem_data_i(mem_data_i), .flag_i(flag_i), .instr_valid_o(instr_valid_o),
    .instr_ready_i(instr_ready_i), .instr_o(instr_o), .resume_i(resume_i),
    .halted_o(halted_o), .illegal_o(illegal_o), .retired_o(retired_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard queues
  typedef struct {
    logic [1:0]    mode;
    logic [NW-1:0] data;
    logic          ill;
  } adv_t;
  logic [AW-1:0] exp_fetch[$];
  adv_t          exp_adv[$];

  // Behavioural PC: advance command latched on negedge, applied on posedge
  logic [AW-1:0] pc_q;
  logic [AW-1:0] pc_rst_val;
  logic [AW-1:0] stk[$];
  logic          rst_s = 1'b0, adv_s = 1'b0;
  logic [1:0]    mode_s = 2'd1;
  logic [NW-1:0] data_s = '0;
  assign pc_addr_i = pc_q;

  always @(posedge clk) begin
    if (rst_s) begin
      pc_q <= pc_rst_val;
      stk.delete();
    end else if (adv_s) begin
      case (mode_s)
        2'd0: pc_q <= (stk.size() != 0) ? stk.pop_back() : '0;
        2'd1: pc_q <= pc_q + AW'(1);
        2'd2: pc_q <= pc_q + {{(AW-NW){data_s[NW-1]}}, data_s};
        default: begin
          stk.push_back(pc_q + AW'(1));
          pc_q <= {{(AW-NW){data_s[NW-1]}}, data_s};
        end
      endcase
    end
  end

  // Program memory with configurable ack latency
  logic [IW-1:0] mem [0:(1<<AW)-1];
  int lat = 1;
  int cnt = 0;
  always @(posedge clk) begin
    #2;
    if (rst_i || mem_ack_i) begin
      mem_ack_i = 1'b0;
      cnt = 0;
    end else if (mem_req_o) begin
      cnt++;
      if (cnt >= lat) begin
        mem_ack_i  = 1'b1;
        mem_data_i = mem[mem_addr_o];
        cnt = 0;
      end
    end else begin
      cnt = 0;
    end
  end

  // Monitor: compare fetch starts and advance cycles against the scoreboard
  logic req_prev = 1'b0;
  always @(negedge clk) begin
    adv_t a;
    rst_s  = rst_i;
    adv_s  = !rst_i && !pc_halt_o;
    mode_s = pc_mode_o;
    data_s = pc_data_o;
    if (!rst_i) begin
      if (mem_req_o && !req_prev) begin
        if (exp_fetch.size() == 0) check("fetch_unexpected", 32'(mem_addr_o), 32'hFFFF);
        else check("fetch_addr", 32'(mem_addr_o), 32'(exp_fetch.pop_front()));
      end
      if (!pc_halt_o) begin
        if (exp_adv.size() == 0) check("advance_unexpected", 32'(pc_mode_o), 32'hFFFF);
        else begin
          a = exp_adv.pop_front();
          check("adv_mode", 32'(pc_mode_o), 32'(a.mode));
          if (a.mode >= 2'd2) check("adv_data", 32'(pc_data_o), 32'(a.data));
          check("adv_illegal", 32'(illegal_o), 32'(a.ill));
        end
      end
      if (instr_o[15:13] == 3'b111) check("halt_hidden", 32'(instr_valid_o), 32'd0);
    end
    req_prev = mem_req_o;
  end

  task automatic push_adv(input logic [1:0] m, input logic [NW-1:0] d, input logic ill);
    adv_t a;
    a.mode = m; a.data = d; a.ill = ill;
    exp_adv.push_back(a);
  endtask

  task automatic rst_on(input logic [AW-1:0] start);
    rst_i = 1'b1;
    pc_rst_val = start;
    exp_fetch.delete();
    exp_adv.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((exp_fetch.size() != 0 || exp_adv.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("scoreboard_drained", 32'(exp_fetch.size() + exp_adv.size()), 32'd0);
    exp_fetch.delete();
    exp_adv.delete();
    #1;
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [IW-1:0] word;
    logic          flag;
    logic [1:0]    mode;
    logic [NW-1:0] data;
    logic [AW-1:0] nxt;
    logic          ill;
  } vec_t;
  vec_t vecs[10];

  initial begin
    int n;
    vecs[0] = '{10'h000, 16'h0000, 1'b0, 2'd1, 8'h00, 10'h001, 1'b0};
    vecs[1] = '{10'h005, 16'h30FD, 1'b1, 2'd2, 8'hFD, 10'h002, 1'b0};
    vecs[2] = '{10'h005, 16'h30FD, 1'b0, 2'd1, 8'hFD, 10'h006, 1'b0};
    vecs[3] = '{10'h005, 16'h20FD, 1'b0, 2'd2, 8'hFD, 10'h002, 1'b0};
    vecs[4] = '{10'h008, 16'h4040, 1'b0, 2'd3, 8'h40, 10'h040, 1'b0};
    vecs[5] = '{10'h007, 16'h8000, 1'b0, 2'd1, 8'h00, 10'h008, 1'b1};
    vecs[6] = '{10'h3FE, 16'hA0F0, 1'b1, 2'd1, 8'hF0, 10'h3FF, 1'b1};
    vecs[7] = '{10'h020, 16'hC000, 1'b0, 2'd1, 8'h00, 10'h021, 1'b1};
    vecs[8] = '{10'h010, 16'h3102, 1'b1, 2'd2, 8'h02, 10'h012, 1'b0};
    vecs[9] = '{10'h100, 16'h2080, 1'b0, 2'd2, 8'h80, 10'h080, 1'b0};

    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    rst_i = 1'b1; flag_i = 1'b0; instr_ready_i = 1'b1; resume_i = 1'b0;
    mem_ack_i = 1'b0; mem_data_i = '0; pc_rst_val = '0;

    // Reset values
    @(negedge clk);
    check("rst_pc_halt", 32'(pc_halt_o), 32'd1);
    check("rst_pc_mode", 32'(pc_mode_o), 32'd1);
    check("rst_pc_data", 32'(pc_data_o), 32'd0);
    check("rst_req", 32'(mem_req_o), 32'd0);
    @(posedge clk); #1;
    check("rst_instr", 32'(instr_o), 32'd0);
    check("rst_retired", 32'(retired_o), 32'd0);
    check("rst_illegal", 32'(illegal_o), 32'd0);

    // Straight-line code at 0..3, halt at 4
    mem[4] = 16'hE000;
    rst_on(10'h000);
    for (int i = 0; i < 5; i++) exp_fetch.push_back(AW'(i));
    for (int i = 0; i < 4; i++) push_adv(2'd1, 8'h00, 1'b0);
    rst_i = 1'b0;
    wait_done(60);
    check("seq_retired", 32'(retired_o), 32'd4);
    check("seq_pc", 32'(pc_q), 32'd4);

    // Single-instruction decode table
    for (int i = 0; i < 10; i++) begin
      mem[vecs[i].addr] = vecs[i].word;
      flag_i = vecs[i].flag;
      rst_on(vecs[i].addr);
      exp_fetch.push_back(vecs[i].addr);
      push_adv(vecs[i].mode, vecs[i].data, vecs[i].ill);
      exp_fetch.push_back(vecs[i].nxt);
      rst_i = 1'b0;
      wait_done(30);
      check("vec_retired", 32'(retired_o), 32'd1);
      check("vec_next_pc", 32'(pc_q), 32'(vecs[i].nxt));
    end
    flag_i = 1'b0;

    // Call then return: 8 -> 0x40 -> 9
    mem[10'h008] = 16'h4040; mem[10'h040] = 16'h6000; mem[10'h009] = 16'h0000;
    rst_on(10'h008);
    exp_fetch.push_back(10'h008); push_adv(2'd3, 8'h40, 1'b0);
    exp_fetch.push_back(10'h040); push_adv(2'd0, 8'h00, 1'b0);
    exp_fetch.push_back(10'h009);
    rst_i = 1'b0;
    wait_done(40);
    check("callret_pc", 32'(pc_q), 32'h9);

    // Downstream stall with 3-cycle memory
    lat = 3;
    mem[10'h00A] = 16'h0011;
    rst_on(10'h00A);
    instr_ready_i = 1'b0;
    exp_fetch.push_back(10'h00A); push_adv(2'd1, 8'h00, 1'b0); exp_fetch.push_back(10'h00B);
    rst_i = 1'b0;
    n = 0;
    while (!instr_valid_o && n < 30) begin @(posedge clk); #1; n++; end
    check("stall_valid_seen", 32'(instr_valid_o), 32'd1);
    repeat (5) begin
      @(negedge clk);
      check("stall_instr", 32'(instr_o), 32'h0011);
      check("stall_pc", 32'(pc_addr_i), 32'h00A);
      check("stall_req", 32'(mem_req_o), 32'd0);
      check("stall_pc_halt", 32'(pc_halt_o), 32'd1);
    end
    @(posedge clk); #1;
    instr_ready_i = 1'b1;
    wait_done(30);
    check("stall_retired", 32'(retired_o), 32'd1);
    lat = 1;

    // Halt at 3, then resume
    mem[10'h003] = 16'hE000; mem[10'h004] = 16'h0000; mem[10'h005] = 16'h0000;
    rst_on(10'h003);
    exp_fetch.push_back(10'h003); push_adv(2'd1, 8'h00, 1'b0);
    rst_i = 1'b0;
    wait_done(30);
    n = 0;
    while (!halted_o && n < 10) begin @(posedge clk); #1; n++; end
    check("halt_halted", 32'(halted_o), 32'd1);
    check("halt_pc", 32'(pc_q), 32'd4);
    check("halt_retired", 32'(retired_o), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("halt_no_req", 32'(mem_req_o), 32'd0);
      check("halt_pc_hold", 32'(pc_halt_o), 32'd1);
    end
    exp_fetch.push_back(10'h004); push_adv(2'd1, 8'h00, 1'b0); exp_fetch.push_back(10'h005);
    @(posedge clk); #1;
    resume_i = 1'b1;
    @(posedge clk); #1;
    resume_i = 1'b0;
    wait_done(30);
    check("resume_retired", 32'(retired_o), 32'd1);

    // Reset while waiting on a slow ack
    lat = 4;
    mem[0] = 16'h0000; mem[1] = 16'h0000; mem[2] = 16'h0000;
    rst_on(10'h000);
    exp_fetch.push_back(10'h000); push_adv(2'd1, 8'h00, 1'b0);
    exp_fetch.push_back(10'h001); push_adv(2'd1, 8'h00, 1'b0);
    exp_fetch.push_back(10'h002);
    rst_i = 1'b0;
    wait_done(60);
    check("midrst_req_before", 32'(mem_req_o), 32'd1);
    check("midrst_retired_before", 32'(retired_o), 32'd2);
    rst_i = 1'b1;
    @(negedge clk);
    check("midrst_req", 32'(mem_req_o), 32'd0);
    exp_fetch.push_back(10'h000);
    @(posedge clk); #1;
    check("midrst_retired", 32'(retired_o), 32'd0);
    check("midrst_pc", 32'(pc_q), 32'd0);
    rst_i = 1'b0;
    wait_done(30);
    check("midrst_refetch_addr", 32'(mem_addr_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
